key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter NKEYS, default 4, number of independent key channels.
REQ-002 SHALL have parameter DEB_CYCLES, default 20, consecutive stable clk cycles required to accept an edge; legal range 2..2^CW-1.
REQ-003 SHALL have parameter REPEAT_DELAY, default 500, clk cycles from initial press pulse to first repeat pulse.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 125, clk cycles between subsequent repeat pulses.
REQ-005 SHALL have parameter CW, default 10, width of every internal counter.
REQ-006 SHALL have port clk  input  1  sole clock (1 kHz tick domain, msclks[14] in traffic).
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port key_n  input  NKEYS  raw asynchronous push-buttons, active-low.
REQ-009 SHALL have port level  output  NKEYS  debounced pressed state, active-high.
REQ-010 SHALL have port press  output  NKEYS  one-cycle pulse per accepted press and per repeat.
REQ-011 SHALL have port toggle  output  NKEYS  flips on each accepted press (pause/run latch).

Function
REQ-012 SHALL pass each key_n bit through a two-flop synchronizer, inverted to active-high, before any use.
REQ-013 SHALL run one independent FSM per channel, states IDLE, DEB_DN, HELD, DEB_UP, with one CW-bit debounce counter and one CW-bit repeat counter.
REQ-014 IDLE: synchronized key 1 -> DEB_DN, debounce counter = 0.
REQ-015 DEB_DN: key 0 -> IDLE; else counter increments; key 1 with counter == DEB_CYCLES-1 -> HELD, level = 1, press = 1 for one cycle, toggle inverted, repeat counter = 0.
REQ-016 Latency: key_n held low from edge 1 SHALL give press high in the cycle following edge DEB_CYCLES+3.
REQ-017 HELD: key 0 -> DEB_UP, debounce counter = 0; level stays 1.
REQ-018 DEB_UP: key 1 -> HELD without pulse or toggle; key 0 with counter == DEB_CYCLES-1 -> IDLE, level = 0; no pulse on release.
REQ-019 A bounce shorter than DEB_CYCLES cycles SHALL produce no change on level, press or toggle.
REQ-020 Debounce counter SHALL never wrap; it is cleared on every state change.
REQ-021 press SHALL never be high on two consecutive cycles for the same channel.
REQ-022 Channels SHALL be fully independent; simultaneous presses on several keys each pulse in the same cycle.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While rst = 1 at a clk edge: synchronizers 0, every FSM IDLE, all counters 0, level/press/toggle 0.
REQ-025 Reset mid-operation SHALL abort any debounce or repeat in progress; a key held through reset release is treated as a new press, counted from the first edge with rst = 0.

Configuration
REQ-026 Macro KEY_CONDITIONER_REPEAT_EN defined: in HELD the repeat counter increments each cycle; at REPEAT_DELAY-1 (first) then REPEAT_PERIOD-1 (later) it pulses press, leaves toggle untouched, and reloads to 0.
REQ-027 Repeat counter SHALL freeze in DEB_UP and resume on return to HELD.
REQ-028 Macro undefined: repeat counter and logic absent; exactly one press pulse per accepted press.

Verification (DEB_CYCLES=20, REPEAT_DELAY=500, REPEAT_PERIOD=125)
REQ-029 key_n[0] low from edge 1, held 100 cycles -> press[0] high one cycle after edge 23, level[0]=1, toggle[0]=1; level[0]=0 22 cycles after release.
REQ-030 key_n[1] 5-cycle low glitches every 10 cycles for 200 cycles -> level, press, toggle stay 0.
REQ-031 REPEAT_EN, key_n[2] held 1000 cycles -> press[2] at edges 23, 523, 648, 773, 898; toggle[2] flips once.
REQ-032 key_n[3] pressed, released, pressed (each 50 cycles stable) -> toggle[3] sequence 0,1,0.
REQ-033 rst pulsed at edge 15 of a press with key still low -> no pulse before reset; press pulse 23 edges after rst deasserts.
REQ-034 all four keys low at same edge -> press = 4'b1111 in one cycle, no other pulses (repeat disabled).

Source files
------------

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// key_conditioner : per-key 2-flop sync, debounce FSM, press pulse and toggle.
// Optional auto-repeat via KEY_CONDITIONER_REPEAT_EN.   Revision: 1.0
// ============================================================================
module key_conditioner #(
  parameter int NKEYS         = 4,
  parameter int DEB_CYCLES    = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 125,
  parameter int CW            = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] level,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] toggle
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DEB_DN = 2'd1,
    S_HELD   = 2'd2,
    S_DEB_UP = 2'd3
  } state_t;

  localparam logic [CW-1:0] C_DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE      = CW'(1);

  // Out-of-range settings would make a counter wrap or never terminate.
  if (NKEYS < 1 || DEB_CYCLES < 2 || DEB_CYCLES > (2**CW) - 1 ||
      REPEAT_DELAY < 2 || REPEAT_DELAY > 2**CW ||
      REPEAT_PERIOD < 2 || REPEAT_PERIOD > 2**CW) begin : g_param_check
    $error("key_conditioner: illegal parameter combination");
  end

  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~key_n;
      r_sync2 <= r_sync1;
    end
  end

  genvar i;
  for (i = 0; i < NKEYS; i++) begin : g_ch
    logic    w_key;
    state_t  r_state, w_state;
    logic [CW-1:0] r_deb, w_deb;
    logic    r_level, w_level;
    logic    r_press, w_press;
    logic    r_toggle, w_toggle;
`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam logic [CW-1:0] C_REP_FIRST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] C_REP_NEXT  = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0] r_rep, w_rep;
    logic          r_first, w_first;
`endif

    assign w_key = r_sync2[i];

    always_comb begin
      w_state  = r_state;
      w_deb    = r_deb;
      w_level  = r_level;
      w_press  = 1'b0;
      w_toggle = r_toggle;
`ifdef KEY_CONDITIONER_REPEAT_EN
      w_rep    = r_rep;
      w_first  = r_first;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_key) begin
            w_state = S_DEB_DN;
            w_deb   = '0;
          end
        end
        S_DEB_DN: begin
          if (!w_key) begin
            w_state = S_IDLE;
            w_deb   = '0;
          end else if (r_deb == C_DEB_LAST) begin
            w_state  = S_HELD;
            w_deb    = '0;
            w_level  = 1'b1;
            w_press  = 1'b1;
            w_toggle = ~r_toggle;
`ifdef KEY_CONDITIONER_REPEAT_EN
            w_rep    = '0;
            w_first  = 1'b1;
`endif
          end else begin
            w_deb = r_deb + C_ONE;
          end
        end
        S_HELD: begin
          if (!w_key) begin
            w_state = S_DEB_UP;
            w_deb   = '0;
          end
`ifdef KEY_CONDITIONER_REPEAT_EN
          // First repeat waits the long delay, later ones the short period.
          else if (r_rep == (r_first ? C_REP_FIRST : C_REP_NEXT)) begin
            w_press = 1'b1;
            w_rep   = '0;
            w_first = 1'b0;
          end else begin
            w_rep = r_rep + C_ONE;
          end
`endif
        end
        S_DEB_UP: begin
          if (w_key) begin
            w_state = S_HELD;
            w_deb   = '0;
          end else if (r_deb == C_DEB_LAST) begin
            w_state = S_IDLE;
            w_deb   = '0;
            w_level = 1'b0;
          end else begin
            w_deb = r_deb + C_ONE;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_deb   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state  <= S_IDLE;
        r_deb    <= '0;
        r_level  <= 1'b0;
        r_press  <= 1'b0;
        r_toggle <= 1'b0;
`ifdef KEY_CONDITIONER_REPEAT_EN
        r_rep    <= '0;
        r_first  <= 1'b0;
`endif
      end else begin
        r_state  <= w_state;
        r_deb    <= w_deb;
        r_level  <= w_level;
        r_press  <= w_press;
        r_toggle <= w_toggle;
`ifdef KEY_CONDITIONER_REPEAT_EN
        r_rep    <= w_rep;
        r_first  <= w_first;
`endif
      end
    end

    assign level[i]  = r_level;
    assign press[i]  = r_press;
    assign toggle[i] = r_toggle;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// tb_key_conditioner : directed key scenarios, expected press events queued
// and checked by an independent monitor.   Revision: 1.0
// ============================================================================
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_n = 4'b1111;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] toggle;

  always #5 clk = ~clk;

  key_conditioner #(
    .NKEYS(4), .DEB_CYCLES(20), .REPEAT_DELAY(500), .REPEAT_PERIOD(125), .CW(10)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .level(level), .press(press), .toggle(toggle)
  );

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] l;
    logic [3:0] t;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] exp_tog = 4'b0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] l, input logic [3:0] t);
    exp_t e;
    e.cyc = c; e.p = p; e.l = l; e.t = t;
    q.push_back(e);
  endtask

  // Monitor: every nonzero press must match the next queued event.
  always @(negedge clk) begin
    if (press !== 4'b0000) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_press: got press=%b at cycle %0d, expected none", press, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("press_cycle", cyc, mon_e.cyc);
        chk("press_vec", {28'd0, press}, {28'd0, mon_e.p});
        chk("level_at_press", {28'd0, level}, {28'd0, mon_e.l});
        chk("toggle_at_press", {28'd0, toggle}, {28'd0, mon_e.t});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t0;
    wait_to(3);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_press", {28'd0, press}, 32'd0);
    chk("rst_toggle", {28'd0, toggle}, 32'd0);
    rst = 1'b0;
    wait_to(6);

    // Single press on key 0, then release timing.
    t0 = cyc;
    key_n[0] = 1'b0;
    exp_tog = 4'b0001;
    push(t0 + 23, 4'b0001, 4'b0001, exp_tog);
    wait_to(t0 + 100);
    key_n[0] = 1'b1;
    wait_to(t0 + 122);
    chk("k0_level_before_drop", {31'd0, level[0]}, 32'd1);
    wait_to(t0 + 123);
    chk("k0_level_dropped", {31'd0, level[0]}, 32'd0);
    chk("k0_toggle_kept", {31'd0, toggle[0]}, 32'd1);

    // Short glitches on key 1 must be ignored.
    t0 = cyc;
    for (int k = 0; k < 20; k++) begin
      key_n[1] = 1'b0;
      wait_to(t0 + 10 * k + 5);
      key_n[1] = 1'b1;
      wait_to(t0 + 10 * k + 10);
    end
    wait_to(t0 + 230);
    chk("glitch_level", {28'd0, level}, 32'd0);
    chk("glitch_toggle", {28'd0, toggle}, {28'd0, exp_tog});

    // Long hold on key 2 (repeat pulses only when the repeat build is used).
    t0 = cyc;
    key_n[2] = 1'b0;
    exp_tog ^= 4'b0100;
    push(t0 + 23, 4'b0100, 4'b0100, exp_tog);
`ifdef KEY_CONDITIONER_REPEAT_EN
    push(t0 + 523, 4'b0100, 4'b0100, exp_tog);
    push(t0 + 648, 4'b0100, 4'b0100, exp_tog);
    push(t0 + 773, 4'b0100, 4'b0100, exp_tog);
    push(t0 + 898, 4'b0100, 4'b0100, exp_tog);
`endif
    wait_to(t0 + 1000);
    key_n[2] = 1'b1;
    wait_to(t0 + 1030);
    chk("k2_level_released", {28'd0, level}, 32'd0);
    chk("k2_toggle", {28'd0, toggle}, {28'd0, exp_tog});

    // Press / release / press on key 3: toggle goes 0,1,0.
    t0 = cyc;
    chk("k3_toggle_0", {31'd0, toggle[3]}, 32'd0);
    key_n[3] = 1'b0;
    exp_tog ^= 4'b1000;
    push(t0 + 23, 4'b1000, 4'b1000, exp_tog);
    wait_to(t0 + 50);
    key_n[3] = 1'b1;
    wait_to(t0 + 100);
    chk("k3_level_between", {28'd0, level}, 32'd0);
    chk("k3_toggle_1", {31'd0, toggle[3]}, 32'd1);
    key_n[3] = 1'b0;
    exp_tog ^= 4'b1000;
    push(t0 + 123, 4'b1000, 4'b1000, exp_tog);
    wait_to(t0 + 150);
    key_n[3] = 1'b1;
    wait_to(t0 + 180);
    chk("k3_toggle_2", {31'd0, toggle[3]}, 32'd0);

    // Reset in the middle of a debounce with the key still held.
    t0 = cyc;
    key_n[0] = 1'b0;
    wait_to(t0 + 14);
    rst = 1'b1;
    wait_to(t0 + 15);
    chk("midrst_level", {28'd0, level}, 32'd0);
    chk("midrst_toggle", {28'd0, toggle}, 32'd0);
    rst = 1'b0;
    exp_tog = 4'b0001;
    push(t0 + 38, 4'b0001, 4'b0001, exp_tog);
    wait_to(t0 + 60);
    key_n[0] = 1'b1;
    wait_to(t0 + 90);

    // All keys pressed on the same edge.
    t0 = cyc;
    key_n = 4'b0000;
    exp_tog ^= 4'b1111;
    push(t0 + 23, 4'b1111, 4'b1111, exp_tog);
    wait_to(t0 + 100);
    key_n = 4'b1111;
    wait_to(t0 + 130);
    chk("all_level_released", {28'd0, level}, 32'd0);
    chk("all_toggle", {28'd0, toggle}, {28'd0, exp_tog});

    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
